// File: rtl/rv32im_ifu.sv
// rv32im instruction fetch unit: owns the fetch PC, issues single outstanding
// word fetches to instruction memory and queues returned words for decode.
// A branch redirect flushes the queue, retargets the PC and discards any
// response that is still in flight.
module rv32im_ifu #(
    parameter int                          API_ADDR_WIDTH = 32,
    parameter int                          API_DATA_WIDTH = 32,
    parameter logic [API_ADDR_WIDTH-1:0]   RESET_PC       = '0,
    parameter int                          BUF_DEPTH      = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      br_taken_i,
    input  logic [API_ADDR_WIDTH-1:0] br_pc_i,
    output logic                      imem_req_o,
    output logic [API_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_ack_i,
    input  logic                      imem_rvalid_i,
    input  logic [API_DATA_WIDTH-1:0] imem_rdata_i,
    output logic                      instr_valid_o,
    output logic [API_DATA_WIDTH-1:0] instr_o,
    output logic [API_ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                      instr_ready_i
);

    localparam int                PTR_W   = $clog2(BUF_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_n;
    logic [API_ADDR_WIDTH-1:0] fetch_pc;
    logic [API_ADDR_WIDTH-1:0] br_target;
    logic [CNT_W-1:0]          count;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [API_ADDR_WIDTH-1:0] buf_pc    [BUF_DEPTH];
    logic [API_DATA_WIDTH-1:0] buf_instr [BUF_DEPTH];
    logic                      push;
    logic                      pop;

    // Redirect target is always word aligned; low two bits are dropped.
    assign br_target = br_pc_i & ~API_ADDR_WIDTH'(3);

    // A response is queued only while the live request is outstanding and no
    // redirect is flushing the queue; a redirect also wins over a pop.
    assign push = (state == S_WAIT) & imem_rvalid_i & ~br_taken_i & ~rst_i;
    assign pop  = instr_valid_o & instr_ready_i & ~br_taken_i;

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? buf_instr[rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? buf_pc[rd_ptr]    : '0;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_REQ;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: a redirect while waiting turns the live request into a
    // killed one unless its response lands in the same cycle.
    always_comb begin
        state_n = state;
        case (state)
            S_REQ: begin
                if (imem_req_o && imem_ack_i) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_n = S_REQ;
                end else if (br_taken_i) begin
                    state_n = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid_i) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    // FSM outputs: request only with guaranteed buffer space; reset and
    // redirect gate the request combinationally so no stale address is acked.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = fetch_pc;
        if ((state == S_REQ) && (count < DEPTH_C) && !br_taken_i && !rst_i) begin
            imem_req_o = 1'b1;
        end
    end

    // Fetch PC and queue bookkeeping; a redirect flushes everything buffered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (br_taken_i) begin
            fetch_pc <= br_target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + API_ADDR_WIDTH'(4);
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage: holds the PC alongside each returned word.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_pc[wr_ptr]    <= fetch_pc;
            buf_instr[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_rv32im_ifu.sv
`timescale 1ns/1ps
// Bench for rv32im_ifu: a behavioural fetch model (next PC, queue of expected
// instructions, outstanding-response status) compared every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_rv32im_ifu;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, br_taken_i, imem_ack_i, imem_rvalid_i, instr_ready_i;
    logic [31:0] br_pc_i, imem_rdata_i;
    logic        imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;

    rv32im_ifu #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .br_taken_i(br_taken_i), .br_pc_i(br_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    int          m_out = 0;     // 0: nothing outstanding, 1: live, 2: killed
    bit          m_known = 0;
    logic [31:0] popped_pc [$];
    logic [31:0] popped_in [$];
    logic [31:0] ack_log [$];
    int          n_acks = 0;

    // memory behaviour knobs
    int          rv_wait = -1;
    logic [31:0] rv_addr = '0;
    int          ack_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100;

    function automatic logic [31:0] image(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic missing(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: expected event never occurred (t=%0t)", name, $time);
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp_pc,
                           input logic [31:0] exp_in);
        if (popped_pc.size() > idx) begin
            chk({name, "_pc"}, popped_pc[idx], exp_pc);
            chk({name, "_instr"}, popped_in[idx], exp_in);
        end else begin
            missing(name);
        end
    endtask

    task automatic chk_ack(input string name, input int idx, input logic [31:0] exp);
        if (ack_log.size() > idx) chk(name, ack_log[idx], exp);
        else missing(name);
    endtask

    task automatic compare();
        logic        exp_req;
        logic [63:0] h;
        if (!m_known) return;
        exp_req = !rst_i && !br_taken_i && (m_out == 0) && (m_q.size() < DEPTH);
        chk("imem_req_o", imem_req_o, exp_req);
        chk("imem_addr_o", imem_addr_o, m_pc);
        chk("instr_valid_o", instr_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) begin
            h = m_q[0];
            chk("instr_pc_o", instr_pc_o, h[63:32]);
            chk("instr_o", instr_o, h[31:0]);
        end else if (rst_i) begin
            chk("instr_o_rst", instr_o, 32'h0);
            chk("instr_pc_o_rst", instr_pc_o, 32'h0);
        end
    endtask

    task automatic model_step(input logic rst, input logic br, input logic [31:0] bpc,
                              input logic ack, input logic rvalid, input logic rdy,
                              input logic exp_req);
        logic [63:0] h;
        if (rst) begin
            m_pc = RST_PC;
            m_q.delete();
            m_out = 0;
            m_known = 1;
        end else if (!m_known) begin
            // nothing known before the first reset
        end else if (br) begin
            m_pc = {bpc[31:2], 2'b00};
            m_q.delete();
            if (m_out != 0) m_out = rvalid ? 0 : 2;
        end else begin
            if (m_q.size() > 0 && rdy) begin
                h = m_q.pop_front();
                popped_pc.push_back(h[63:32]);
                popped_in.push_back(h[31:0]);
            end
            if (m_out != 0 && rvalid) begin
                if (m_out == 1) begin
                    m_q.push_back({m_pc, image(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                m_out = 0;
            end else if (exp_req && ack) begin
                m_out = 1;
            end
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input logic rst, input logic br, input logic [31:0] bpc);
        logic exp_req;
        rst_i         = rst;
        br_taken_i    = br;
        br_pc_i       = br ? bpc : $urandom();
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom();
        imem_ack_i    = 1'b0;
        if (rv_wait == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = image(rv_addr);
            rv_wait       = -1;
        end else if (rv_wait > 0) begin
            rv_wait--;
        end
        #1;
        compare();
        exp_req = m_known && !rst && !br && (m_out == 0) && (m_q.size() < DEPTH);
        if (imem_req_o && rv_wait < 0 && $urandom_range(99) < ack_pct) begin
            imem_ack_i = 1'b1;
            rv_addr    = imem_addr_o;
            rv_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
            ack_log.push_back(imem_addr_o);
            n_acks++;
        end
        model_step(rst, br, bpc, imem_ack_i, imem_rvalid_i, instr_ready_i, exp_req);
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        popped_pc.delete();
        popped_in.delete();
        ack_log.delete();
        n_acks = 0;
    endtask

    initial begin
        int base;
        int r;
        logic [31:0] bpc;

        // reset with single-cycle memory and decode always ready
        ack_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100;
        do_reset();
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_addr", imem_addr_o, 32'h0000_0100);
        chk("rst_valid", instr_valid_o, 1'b0);
        rst_i = 1'b0; br_taken_i = 1'b0;
        #1;
        chk("first_req", imem_req_o, 1'b1);
        chk("first_addr", imem_addr_o, 32'h0000_0100);
        run(6);
        base = popped_pc.size();
        run(20);
        chk("throughput_pops", popped_pc.size() - base, 10);
        chk_pop("seq0", 0, 32'h0000_0100, 32'hDEAD_0100);
        chk_pop("seq1", 1, 32'h0000_0104, 32'hDEAD_0104);
        chk_pop("seq2", 2, 32'h0000_0108, 32'hDEAD_0108);

        // decode stalled: buffer fills to depth and requests stop
        do_reset();
        rdy_pct = 0;
        run(10);
        chk("stall_acks", n_acks, 2);
        chk("stall_valid", instr_valid_o, 1'b1);
        chk("stall_req", imem_req_o, 1'b0);
        rdy_pct = 100;
        run(10);
        chk_pop("stall_pop0", 0, 32'h0000_0100, 32'hDEAD_0100);
        chk_pop("stall_pop1", 1, 32'h0000_0104, 32'hDEAD_0104);
        chk_pop("stall_pop2", 2, 32'h0000_0108, 32'hDEAD_0108);

        // redirect while waiting, response arrives three cycles later
        lat_min = 4; lat_max = 4;
        do_reset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_2002);
        lat_min = 1; lat_max = 1;
        run(12);
        chk_ack("wait_redir_ack", 1, 32'h0000_2000);
        chk_pop("wait_redir_pop", 0, 32'h0000_2000, 32'hDEAD_2000);

        // redirect in the same cycle as a response with one entry buffered
        rdy_pct = 0;
        do_reset();
        run(3);
        chk("pre_redir_valid", instr_valid_o, 1'b1);
        tick(1'b0, 1'b1, 32'h0000_0400);
        chk("post_redir_valid", instr_valid_o, 1'b0);
        rdy_pct = 100;
        run(10);
        chk_ack("rv_redir_ack", 2, 32'h0000_0400);
        chk_pop("rv_redir_pop", 0, 32'h0000_0400, 32'hDEAD_0400);

        // redirect during S_REQ with memory not acking
        ack_pct = 0;
        do_reset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0800);
        br_taken_i = 1'b0;
        #1;
        chk("req_redir_addr", imem_addr_o, 32'h0000_0800);
        chk("req_redir_req", imem_req_o, 1'b1);
        ack_pct = 100;
        run(10);
        chk_ack("req_redir_ack0", 0, 32'h0000_0800);
        chk_ack("req_redir_ack1", 1, 32'h0000_0804);
        chk_pop("req_redir_pop0", 0, 32'h0000_0800, 32'hDEAD_0800);
        chk_pop("req_redir_pop1", 1, 32'h0000_0804, 32'hDEAD_0804);

        // PC wrap at the top of the address space
        do_reset();
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        run(10);
        chk_pop("wrap0", 0, 32'hFFFF_FFFC, 32'h2152_FFFC);
        chk_pop("wrap1", 1, 32'h0000_0000, 32'hDEAD_0000);

        // reset while waiting; the late response must be ignored
        lat_min = 3; lat_max = 3;
        do_reset();
        tick(1'b0, 1'b1, 32'h0000_3000);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        lat_min = 1; lat_max = 1;
        run(12);
        chk_ack("rst_wait_ack0", 0, 32'h0000_3000);
        chk_ack("rst_wait_ack1", 1, 32'h0000_0100);
        chk_pop("rst_wait_pop", 0, 32'h0000_0100, 32'hDEAD_0100);

        // randomized soak
        ack_pct = 60; lat_min = 1; lat_max = 4; rdy_pct = 70;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(199));
            bpc = (r == 1) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            tick(r == 0, (r >= 1) && (r <= 8), bpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32im_ifu.md
# rv32im_ifu

Instruction fetch unit for the rv32im core: owns the architectural fetch PC, issues word fetches to instruction memory over a request/response handshake, and buffers returned instructions for decode. It consumes the redirect produced by the branch unit (`br_pc_o` plus a taken flag). Any redirect flushes in-flight and buffered instructions and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: instruction buffer entries (power of two, ≥2).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `br_taken_i` in 1: redirect request from the branch unit.
- `br_pc_i` in `API_ADDR_WIDTH`: redirect target. Bits [1:0] are forced to 0.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out `API_ADDR_WIDTH`: word-aligned fetch address.
- `imem_ack_i` in 1: memory accepts the request this cycle (valid only while `imem_req_o`=1).
- `imem_rvalid_i` in 1: read data valid. Earliest is one cycle after ack; exactly one per ack.
- `imem_rdata_i` in `API_DATA_WIDTH`: instruction word.
- `instr_valid_o` out 1: buffer head valid.
- `instr_o` out `API_DATA_WIDTH`: head instruction.
- `instr_pc_o` out `API_ADDR_WIDTH`: PC of the head instruction.
- `instr_ready_i` in 1: decode consumes the head when `instr_valid_o`=1.

## Operation
- Registers: `fetch_pc`, FSM state, FIFO of {pc, instr} with count, and `kill` (the current outstanding response is discarded).
- FSM states:
  - S_REQ:
    - `imem_req_o` = (count < BUF_DEPTH) & ~`br_taken_i`; `imem_addr_o` = `fetch_pc`.
    - Ack with no redirect → S_WAIT.
    - Ack in the same cycle as a redirect is impossible, because req is gated off.
  - S_WAIT:
    - One request is outstanding; `imem_req_o`=0.
    - On rvalid with no redirect: push {`fetch_pc`, rdata}, `fetch_pc` += 4, → S_REQ.
  - S_DISCARD:
    - A killed request is outstanding; `imem_req_o`=0.
    - On rvalid: drop the data, → S_REQ.
- Space rule: count plus outstanding never exceeds BUF_DEPTH. A request issues only if count < BUF_DEPTH. A pop in the same cycle as a push is allowed.
- Redirect (`br_taken_i`=1, any state):
  - `fetch_pc` ← {br_pc_i[31:2], 2'b00}; FIFO flushed (count ← 0).
  - In S_REQ: stay in S_REQ.
  - In S_WAIT without rvalid: → S_DISCARD.
  - In S_WAIT with rvalid that same cycle: data dropped, → S_REQ.
  - In S_DISCARD without rvalid: stay in S_DISCARD. With rvalid: → S_REQ.
  - Redirect beats pop and push; `instr_ready_i` is ignored that cycle.
- Address arithmetic: 32-bit PC += 4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
- Output values: `instr_o`/`instr_pc_o` are don't-care while `instr_valid_o`=0.

## Timing
- Reset values:
  - state = S_REQ, `fetch_pc` = RESET_PC, count = 0.
  - `instr_valid_o`=0, `imem_req_o`=0 during reset.
  - `imem_addr_o`=RESET_PC, `instr_o`=0, `instr_pc_o`=0.
- First request: `imem_req_o`=1 in the first cycle after `rst_i` deasserts.
- `imem_req_o`/`imem_addr_o` are decoded from registered state and count. The only combinational input is `br_taken_i` gating req.
- An ack completes the request in that same cycle.
- Push at the rvalid edge → `instr_valid_o`=1 in the next cycle.
- Single-cycle memory (ack, rvalid next cycle) sustains one instruction every 2 cycles.
- Redirect in cycle N → `instr_valid_o`=0 in N+1, and a request to the target in N+1 (S_REQ case) or one cycle after the discarded rvalid.
- Reset mid-operation: everything returns to reset values at the next edge. An outstanding response arriving after reset is ignored, because state is S_REQ, not S_WAIT.

## Test plan
- Reset with RESET_PC=32'h100, memory acks immediately and returns data next cycle, `instr_ready_i`=1 → addresses 100, 104, 108 in order; `instr_pc_o`/`instr_o` match the memory image.
- `instr_ready_i`=0 for 10 cycles, BUF_DEPTH=2 → exactly 2 pushes, then `imem_req_o` stays 0. Raise ready → pops in order at 100, 104, then fetch resumes at 108.
- Redirect to 32'h0000_2002 while in S_WAIT, rvalid 3 cycles later → that data never appears on `instr_o`. The next request goes to 32'h2000, and the first valid `instr_pc_o`=32'h2000.
- Redirect to 32'h400 in the same cycle as rvalid, with 1 entry already buffered → buffer empty the next cycle. The request to 400 follows, and no stale instruction is emitted.
- Redirect during S_REQ with memory never acking → `imem_addr_o` switches to the target the next cycle and no request is lost or duplicated.
- Start fetch at 32'hFFFF_FFFC → the next address is 32'h0000_0000. Assert `rst_i` while in S_WAIT, with rvalid arriving after reset → the response is ignored and fetch restarts at RESET_PC.
